flop_compare_monitor: RTL and testbench
=======================================

# flop_compare_monitor

Synthesizable checker that sits directly downstream of the spec-vs-impl flop comparison stage. It consumes the per-check `ok` equivalence bits, which are one per compared flop pair, and replaces the free-running `$display` on failure with a stateful scoreboard. The scoreboard keeps saturating per-check failure counts, records the first failure's cycle and index, and streams a per-check report over a valid/ready handshake when the run is stopped.

## Interface
- `NCHECKS`, 16: number of `ok` inputs (≥2).
- `CNTW`, 16: width of each per-check failure counter and of `fail_cycles`.
- `TSW`, 32: width of the sample-cycle timestamp.
- `SETTLE`, 2: number of sample strobes ignored after `arm` (flops power up X).
- `IDXW`, `$clog2(NCHECKS)`: derived; not overridden.

Ports:
- `clk` in 1: sole clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `arm` in 1: start a run; honoured only in IDLE.
- `stop` in 1: end a run; honoured only in SETTLE/RUN.
- `sample` in 1: strobe marking a cycle where `ok` is stable.
- `ok` in NCHECKS: 1 = pass; any other value (0, X, Z) = fail.
- `busy` out 1: high in SETTLE, RUN, DUMP.
- `any_fail` out 1: sticky; set on first counted failure of a run.
- `first_ts` out TSW: timestamp of first counted failure.
- `first_idx` out IDXW: lowest failing index at first failure.
- `fail_cycles` out CNTW: saturating count of sampled cycles with ≥1 failure.
- `dump_valid` out 1, `dump_ready` in 1: report handshake.
- `dump_idx` out IDXW, `dump_count` out CNTW: current report record.
- `done` out 1: one-cycle pulse after last record accepted.

## Operation
- States: IDLE, SETTLE, RUN, DUMP.
- IDLE: `arm` clears all counters, `ts`, `any_fail`, `first_*`, and `settle_cnt`, then goes to SETTLE. Results of the previous run stay readable in IDLE until the next `arm`.
- SETTLE: each `sample` increments `settle_cnt`. `ok` is ignored. When `settle_cnt` reaches SETTLE, go to RUN. SETTLE=0 goes straight to RUN.
- RUN, for each `sample`:
  - `ts` increments (saturating at all-ones).
  - Each failing bit i increments `cnt[i]`, saturating at 2^CNTW−1.
  - If any bit fails, `fail_cycles` increments (saturating).
  - On the first failure of the run, `any_fail`←1, `first_ts`←current `ts` (pre-increment value), and `first_idx`←lowest failing index.
- `stop` in SETTLE or RUN goes to DUMP with `dump_idx`=0. If `stop` and `sample` arrive in the same cycle in RUN, the sample is still counted.
- DUMP: `dump_valid`=1, `dump_count`=`cnt[dump_idx]`.
  - On `dump_valid && dump_ready`, `dump_idx` increments.
  - Acceptance at `dump_idx`=NCHECKS−1 goes to IDLE and pulses `done`.
  - `dump_idx`/`dump_count` are held stable while `dump_ready`=0.
- `arm` outside IDLE is ignored. `stop` in IDLE or DUMP is ignored.
- Fail test is per-bit: a bit fails when `ok[i] !== 1'b1`, implemented as `~(ok[i] === 1'b1)` so that X/Z count as failures in simulation.

## Timing
- Reset values: state IDLE; `busy`=0, `any_fail`=0, `first_ts`=0, `first_idx`=0, `fail_cycles`=0, all `cnt`=0, `dump_valid`=0, `dump_idx`=0, `dump_count`=0, `done`=0.
- `reset` has priority over every other input in every state. Reset mid-DUMP drops `dump_valid` on the next edge and does not pulse `done`.
- Latency:
  - `ok` sampled at edge N is visible in `cnt`, `fail_cycles`, and `any_fail` after edge N (registered, 1 cycle).
  - `busy` rises the cycle after `arm`.
  - `dump_valid` rises the cycle after `stop`.
- Throughput: one record per cycle when `dump_ready` is held high. A full dump takes exactly NCHECKS cycles, and `done` is asserted in the cycle after the last handshake.
- `first_*` never change after `any_fail`=1 within a run.

## Test plan
- Reset, `arm`, SETTLE=2, `ok` all ones for 10 samples, `stop`, `dump_ready`=1: expect 16 records with count 0, `any_fail`=0, `done` 16 cycles after `dump_valid` rises.
- `ok[5]`=0 and `ok[9]`=X together on sample ts=3 only: expect `first_ts`=3, `first_idx`=5, `cnt[5]`=`cnt[9]`=1, `fail_cycles`=1.
- `ok` all zeros for the two SETTLE samples, then all ones: expect `any_fail`=0, all counts 0.
- CNTW=4, `ok[0]`=0 for 20 samples: `cnt[0]`=15 (saturated), `fail_cycles`=15.
- During DUMP, toggle `dump_ready` 1,0,0,1: `dump_idx` holds through the stall with no skipped or duplicated index; assert `reset` at `dump_idx`=7 and expect `busy`=0, `dump_valid`=0, no `done`.
- `stop` and a failing `sample` in the same cycle: the failure is counted; `arm` during DUMP is ignored.

Source files
------------

// File: rtl/flop_compare_monitor.sv
// Scoreboard for the per-flop equivalence bits: saturating per-check failure counts,
// first-failure capture, and a per-check report streamed over a valid/ready handshake.
module flop_compare_monitor #(
   parameter int NCHECKS = 16,
   parameter int CNTW    = 16,
   parameter int TSW     = 32,
   parameter int SETTLE  = 2,
   localparam int IDXW   = $clog2(NCHECKS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               arm,
   input  logic               stop,
   input  logic               sample,
   input  logic [NCHECKS-1:0] ok,
   output logic               busy,
   output logic               any_fail,
   output logic [TSW-1:0]     first_ts,
   output logic [IDXW-1:0]    first_idx,
   output logic [CNTW-1:0]    fail_cycles,
   output logic               dump_valid,
   input  logic               dump_ready,
   output logic [IDXW-1:0]    dump_idx,
   output logic [CNTW-1:0]    dump_count,
   output logic               done
);

   // Handshake: a record (dump_idx, dump_count) transfers on any posedge where
   // dump_valid && dump_ready; while dump_ready is low the record is held unchanged.

   localparam int SW = $clog2(SETTLE + 2);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN, S_DUMP} state_t;

   state_t             state, state_nxt;
   logic [CNTW-1:0]    cnt [NCHECKS];
   logic [TSW-1:0]     ts;
   logic [SW-1:0]      settle_cnt;
   logic [NCHECKS-1:0] fail;
   logic               any_now;
   logic [IDXW-1:0]    low_idx;
   logic               take_sample;
   logic               settle_done;
   logic               last_acc;
   logic               stop_ok;

   // X/Z on an ok bit must count as a failure, hence the case-equality test.
   always_comb begin
      for (int i = 0; i < NCHECKS; i++) begin
         fail[i] = ~(ok[i] === 1'b1);
      end
   end

   always_comb begin
      any_now = |fail;
      low_idx = '0;
      for (int i = NCHECKS - 1; i >= 0; i--) begin
         if (fail[i]) low_idx = IDXW'(i);
      end
   end

   assign take_sample = (state == S_RUN) && sample;
   assign settle_done = sample && (settle_cnt == SW'(SETTLE - 1));
   assign last_acc    = (state == S_DUMP) && dump_ready && (dump_idx == IDXW'(NCHECKS - 1));
   assign stop_ok     = stop && ((state == S_SETTLE) || (state == S_RUN));

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (arm) state_nxt = (SETTLE == 0) ? S_RUN : S_SETTLE;
         S_SETTLE: begin
            if (stop)             state_nxt = S_DUMP;
            else if (settle_done) state_nxt = S_RUN;
         end
         S_RUN:    if (stop) state_nxt = S_DUMP;
         S_DUMP:   if (last_acc) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         ts          <= '0;
         settle_cnt  <= '0;
         any_fail    <= 1'b0;
         first_ts    <= '0;
         first_idx   <= '0;
         fail_cycles <= '0;
         dump_idx    <= '0;
         done        <= 1'b0;
         for (int i = 0; i < NCHECKS; i++) cnt[i] <= '0;
      end else begin
         state <= state_nxt;
         done  <= last_acc;

         if ((state == S_IDLE) && arm) begin
            ts          <= '0;
            settle_cnt  <= '0;
            any_fail    <= 1'b0;
            first_ts    <= '0;
            first_idx   <= '0;
            fail_cycles <= '0;
            for (int i = 0; i < NCHECKS; i++) cnt[i] <= '0;
         end

         if ((state == S_SETTLE) && sample) settle_cnt <= settle_cnt + 1'b1;

         // A sample arriving together with stop is still part of the run.
         if (take_sample) begin
            if (ts != '1) ts <= ts + 1'b1;
            for (int i = 0; i < NCHECKS; i++) begin
               if (fail[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
            end
            if (any_now && (fail_cycles != '1)) fail_cycles <= fail_cycles + 1'b1;
            if (any_now && !any_fail) begin
               any_fail  <= 1'b1;
               first_ts  <= ts;
               first_idx <= low_idx;
            end
         end

         if (stop_ok) begin
            dump_idx <= '0;
         end else if ((state == S_DUMP) && dump_ready) begin
            dump_idx <= last_acc ? '0 : dump_idx + 1'b1;
         end
      end
   end

   assign busy       = (state != S_IDLE);
   assign dump_valid = (state == S_DUMP);
   assign dump_count = dump_valid ? cnt[dump_idx] : '0;

endmodule

// File: tb/tb_flop_compare_monitor.sv
// Directed bench for flop_compare_monitor: a vector table for the run phase plus
// hand-written sequences for settle, dump stalls, reset mid-dump and saturation.
module tb_flop_compare_monitor;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        reset, arm, stop, sample, dump_ready;
   logic [N-1:0] ok;
   logic        busy, any_fail, dump_valid, done;
   logic [31:0] first_ts;
   logic [3:0]  first_idx, dump_idx;
   logic [15:0] fail_cycles, dump_count;

   // Narrow-counter instance for the saturation check.
   logic        arm_s, stop_s, sample_s, dump_ready_s;
   logic [N-1:0] ok_s;
   logic        busy_s, any_fail_s, dump_valid_s, done_s;
   logic [31:0] first_ts_s;
   logic [3:0]  first_idx_s, dump_idx_s;
   logic [3:0]  fail_cycles_s, dump_count_s;

   int tests = 0;
   int fails = 0;
   int exp_cnt [N];
   int cyc;

   typedef struct {
      logic [N-1:0] ok;
      logic         exp_any;
      logic [15:0]  exp_fc;
      logic [31:0]  exp_ts;
      logic [3:0]   exp_idx;
   } vec_t;
   vec_t tbl [8];

   logic ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   always #5 clk = ~clk;

   flop_compare_monitor dut (
      .clk(clk), .reset(reset), .arm(arm), .stop(stop), .sample(sample), .ok(ok),
      .busy(busy), .any_fail(any_fail), .first_ts(first_ts), .first_idx(first_idx),
      .fail_cycles(fail_cycles), .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_idx(dump_idx), .dump_count(dump_count), .done(done)
   );

   flop_compare_monitor #(.CNTW(4)) dut_s (
      .clk(clk), .reset(reset), .arm(arm_s), .stop(stop_s), .sample(sample_s), .ok(ok_s),
      .busy(busy_s), .any_fail(any_fail_s), .first_ts(first_ts_s), .first_idx(first_idx_s),
      .fail_cycles(fail_cycles_s), .dump_valid(dump_valid_s), .dump_ready(dump_ready_s),
      .dump_idx(dump_idx_s), .dump_count(dump_count_s), .done(done_s)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_sample(input logic [N-1:0] v);
      ok     = v;
      sample = 1'b1;
      tick();
      sample = 1'b0;
      ok     = '1;
   endtask

   task automatic model_sample(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i] !== 1'b1) exp_cnt[i]++;
   endtask

   // Walks a whole dump, checking every record against exp_cnt; returns cycles from
   // the first valid record to the done pulse.
   task automatic dump_run(input logic stall_mode, output int cycles);
      int  idx = 0;
      int  k   = 0;
      logic r;
      while (idx < N && k < 200) begin
         chk("dump_valid", dump_valid, 1);
         chk("dump_idx", dump_idx, idx);
         chk("dump_count", dump_count, exp_cnt[idx]);
         chk("done_early", done, 0);
         r          = stall_mode ? ready_pat[k % 4] : 1'b1;
         dump_ready = r;
         arm        = stall_mode && (k == 1);
         tick();
         k++;
         if (r) idx++;
      end
      dump_ready = 1'b0;
      arm        = 1'b0;
      chk("dump_records", idx, N);
      cycles = k;
      chk("done_pulse", done, 1);
      chk("dump_valid_end", dump_valid, 0);
      chk("busy_end", busy, 0);
      tick();
      chk("done_one_cycle", done, 0);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         tbl[i].ok      = '1;
         tbl[i].exp_any = (i >= 3);
         tbl[i].exp_fc  = (i >= 3) ? 16'd1 : 16'd0;
         tbl[i].exp_ts  = (i >= 3) ? 32'd3 : 32'd0;
         tbl[i].exp_idx = (i >= 3) ? 4'd5 : 4'd0;
      end
      tbl[3].ok[5] = 1'b0;
      tbl[3].ok[9] = 1'bx;

      reset = 1'b1; arm = 0; stop = 0; sample = 0; dump_ready = 0; ok = '1;
      arm_s = 0; stop_s = 0; sample_s = 0; dump_ready_s = 0; ok_s = '1;
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_any_fail", any_fail, 0);
      chk("rst_first_ts", first_ts, 0);
      chk("rst_first_idx", first_idx, 0);
      chk("rst_fail_cycles", fail_cycles, 0);
      chk("rst_dump_valid", dump_valid, 0);
      chk("rst_dump_idx", dump_idx, 0);
      chk("rst_dump_count", dump_count, 0);
      chk("rst_done", done, 0);
      reset = 1'b0;
      tick();

      // Clean run; failures during the settle samples must be ignored.
      for (int i = 0; i < N; i++) exp_cnt[i] = 0;
      arm = 1'b1; tick(); arm = 1'b0;
      chk("arm_busy", busy, 1);
      do_sample('0);
      do_sample('0);
      chk("settle_any_fail", any_fail, 0);
      for (int i = 0; i < 10; i++) do_sample('1);
      chk("clean_fail_cycles", fail_cycles, 0);
      stop = 1'b1; tick(); stop = 1'b0;
      chk("stop_dump_valid", dump_valid, 1);
      dump_run(1'b0, cyc);
      chk("dump_cycles", cyc, N);
      chk("clean_any_fail", any_fail, 0);

      // Table run: ok[5]=0 and ok[9]=X at ts=3 only.
      for (int i = 0; i < N; i++) exp_cnt[i] = 0;
      arm = 1'b1; tick(); arm = 1'b0;
      do_sample('1);
      do_sample('1);
      for (int t = 0; t < 8; t++) begin
         model_sample(tbl[t].ok);
         do_sample(tbl[t].ok);
         chk("tbl_any_fail", any_fail, tbl[t].exp_any);
         chk("tbl_fail_cycles", fail_cycles, tbl[t].exp_fc);
         chk("tbl_first_ts", first_ts, tbl[t].exp_ts);
         chk("tbl_first_idx", first_idx, tbl[t].exp_idx);
      end
      chk("tbl_model_cnt5", exp_cnt[5], 1);

      // stop with a failing sample in the same cycle: the sample still counts.
      ok = ~16'h0001; sample = 1'b1; stop = 1'b1;
      model_sample(ok);
      tick();
      sample = 1'b0; stop = 1'b0; ok = '1;
      chk("stop_sample_dv", dump_valid, 1);
      chk("stop_sample_fc", fail_cycles, 2);
      chk("first_ts_held", first_ts, 3);
      chk("first_idx_held", first_idx, 5);
      dump_run(1'b1, cyc);
      chk("idle_any_fail", any_fail, 1);
      chk("idle_first_ts", first_ts, 3);

      // Reset in the middle of a dump.
      arm = 1'b1; tick(); arm = 1'b0;
      do_sample('1);
      do_sample('1);
      for (int i = 0; i < 3; i++) do_sample('1);
      stop = 1'b1; tick(); stop = 1'b0;
      dump_ready = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      chk("pre_reset_idx", dump_idx, 7);
      chk("pre_reset_dv", dump_valid, 1);
      reset = 1'b1; tick(); reset = 1'b0; dump_ready = 1'b0;
      chk("mid_reset_busy", busy, 0);
      chk("mid_reset_dv", dump_valid, 0);
      chk("mid_reset_done", done, 0);
      tick();
      chk("post_reset_done", done, 0);
      chk("post_reset_idx", dump_idx, 0);

      // 4-bit counters saturate at 15.
      arm_s = 1'b1; tick(); arm_s = 1'b0;
      for (int i = 0; i < 22; i++) begin
         ok_s = (i < 2) ? 16'hffff : ~16'h0001;
         sample_s = 1'b1; tick(); sample_s = 1'b0;
      end
      ok_s = '1;
      stop_s = 1'b1; tick(); stop_s = 1'b0;
      chk("sat_fail_cycles", fail_cycles_s, 15);
      chk("sat_dv", dump_valid_s, 1);
      chk("sat_cnt0", dump_count_s, 15);
      dump_ready_s = 1'b1; tick();
      chk("sat_cnt1", dump_count_s, 0);
      for (int i = 0; i < N - 1; i++) tick();
      chk("sat_done", done_s, 1);
      dump_ready_s = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
